// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-port RAM arbiter slice: FSM state encoding,
// RAM direction constants and the default address/line widths.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  // Default RAM geometry: 10-bit line address, 20-bit line (two 10-bit words)
  localparam int ADDR_W_DEF  = 10;
  localparam int DATA_W_DEF  = 20;
  localparam int TIMEOUT_DEF = 16;

  // RAM direction encoding as seen on rw0/rw1/mem_rw
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY    = 2'b01,
    RELEASE = 2'b10
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin selector.
//   req0, req1  : pending requests
//   last_grant  : port that won the previous arbitration
//   winner      : selected port (0 or 1), meaningful only when valid=1
//   valid       : at least one request is pending
// On a tie the port opposite last_grant wins, which gives strict
// alternation under continuous contention.
// ---------------------------------------------------------------------------
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic winner,
  output logic valid
);

  // Tie goes to the port that did not win last; otherwise the lone requester
  always_comb begin
    valid  = req0 | req1;
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last_grant;
    end else begin
      winner = req1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one RAM port (req/ready handshake) between two cache controllers.
// A winning request is latched in IDLE, held on the RAM port through BUSY
// until mem_ready, answered with a one-cycle done pulse, and followed by a
// single RELEASE cycle with mem_req low before re-arbitrating round-robin.
//
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   req0/1, rw0/1       request and direction (1 = write) per cache port
//   addr0/1, wdata0/1   line address and write line per cache port
//   done0/1             one-cycle completion pulse per cache port
//   rdata               read line, valid while done0/done1 is high
//   mem_req, mem_rw     RAM request and direction
//   mem_addr, mem_wdata RAM address and write line
//   mem_rdata, mem_ready RAM read line and completion
//   err                 sticky timeout flag
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN
//   Defined   : BUSY aborts after TIMEOUT cycles without mem_ready, pulsing
//               done with rdata=0 and setting err until reset.
//   Undefined : BUSY waits indefinitely, err is tied low.
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef MEM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              pick_winner;
  logic              pick_valid;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_q, err_d;
`endif

  rr_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  // State and output registers; reset forces mem_req low immediately so the
  // RAM sees an aborted transaction without waiting for a clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      mem_req_q    <= mem_req_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  // Next-state logic. Everything holds by default and done is a pulse, so
  // only the cycles that change something assign it. While BUSY the latched
  // RAM-side values are never touched, which freezes them against requester
  // input changes.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mem_req_d    = mem_req_q;
    mem_rw_d     = mem_rw_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_cnt_d    = '0;
    err_d        = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d      = pick_winner;
          last_grant_d = pick_winner;
          mem_req_d    = 1'b1;
          mem_rw_d     = pick_winner ? rw1    : rw0;
          mem_addr_d   = pick_winner ? addr1  : addr0;
          mem_wdata_d  = pick_winner ? wdata1 : wdata0;
          state_d      = BUSY;
        end
      end

      BUSY: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          if (mem_rw_q == RW_READ) begin
            rdata_d = mem_rdata;
          end
          done0_d = ~grant_q;
          done1_d = grant_q;
          state_d = RELEASE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        // Counter value k means k edges have passed in BUSY without
        // mem_ready, so the abort lands TIMEOUT edges after mem_req rose
        else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          rdata_d   = '0;
          done0_d   = ~grant_q;
          done1_d   = grant_q;
          err_d     = 1'b1;
          state_d   = RELEASE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end

      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_req   = mem_req_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;
  assign done0     = done0_q;
  assign done1     = done1_q;

`ifdef MEM_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scoreboard bench for mem_port_arbiter. Stimulus pushes the
// expected transaction (port, RAM-side fields, returned line, err) into a
// queue; a monitor compares RAM-side outputs against the queue head while
// mem_req is high and pops/compares on every done pulse. A small RAM model
// answers mem_req after a configurable latency.
// Define MEM_ARB_TIMEOUT_EN to also exercise the timeout abort.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        port;
    logic        rw;
    logic [9:0]  addr;
    logic [19:0] wdata;
    logic [19:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req0, req1, rw0, rw1;
  logic [9:0]  addr0, addr1;
  logic [19:0] wdata0, wdata1;
  logic        done0, done1;
  logic [19:0] rdata;
  logic        mem_req, mem_rw;
  logic [9:0]  mem_addr;
  logic [19:0] mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        err;

  exp_t        exp_q[$];
  int          vectors;
  int          miscompares;
  int          cycle;
  int          last_rise;
  int          last_interval;
  int          last_done_cycle;
  int          done_count;
  int          ram_latency;
  bit          ram_enable;
  logic        prev_mem_req;
  logic [19:0] ram_mem [0:1023];

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .rw0       (rw0),
    .rw1       (rw1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .done0     (done0),
    .done1     (done1),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cycle = 0;
    forever begin
      @(posedge clk);
      cycle = cycle + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors = vectors + 1;
    if (actual !== expected) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic port, input logic req, input logic rw,
                               input logic [9:0] addr, input logic [19:0] wdata);
    if (port) begin
      req1 = req; rw1 = rw; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = req; rw0 = rw; addr0 = addr; wdata0 = wdata;
    end
  endtask

  task automatic expect_txn(input logic port, input logic rw, input logic [9:0] addr,
                            input logic [19:0] wdata, input logic [19:0] rd,
                            input logic e);
    exp_t t;
    t.port = port; t.rw = rw; t.addr = addr; t.wdata = wdata; t.rdata = rd; t.err = e;
    exp_q.push_back(t);
  endtask

  // Returns in the cycle after the target done pulse, early enough for the
  // requester to drop req before the arbiter is back in IDLE
  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_count < target && n < budget) begin
      @(posedge clk);
      #2;
      n = n + 1;
    end
    checkOutput("done_within_budget", 32'(done_count >= target), 32'd1);
  endtask

  // RAM model: answers each new mem_req after ram_latency edges
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '1;
    forever begin
      @(negedge clk);
      if (ram_enable && rst && mem_req && !mem_ready) begin
        repeat (ram_latency - 1) @(negedge clk);
        mem_ready = 1'b1;
        if (mem_rw) ram_mem[mem_addr] = mem_wdata;
        else        mem_rdata = ram_mem[mem_addr];
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = '1;
      end
    end
  end

  // Monitor: RAM-side fields against the queue head while BUSY, and the
  // returned line/port/err against the popped entry on each done pulse
  initial begin
    exp_t t;
    prev_mem_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (mem_req && !prev_mem_req) begin
          last_interval = cycle - last_rise;
          last_rise     = cycle;
        end
        if (mem_req) begin
          if (exp_q.size() == 0) begin
            checkOutput("mem_req_unexpected", 32'(mem_req), 32'd0);
          end else begin
            t = exp_q[0];
            checkOutput("mem_rw",    32'(mem_rw),    32'(t.rw));
            checkOutput("mem_addr",  32'(mem_addr),  32'(t.addr));
            checkOutput("mem_wdata", 32'(mem_wdata), 32'(t.wdata));
          end
        end
        if (done0 || done1) begin
          last_done_cycle = cycle;
          done_count      = done_count + 1;
          if (exp_q.size() == 0) begin
            checkOutput("done_unexpected", 32'({done1, done0}), 32'd0);
          end else begin
            t = exp_q.pop_front();
            checkOutput("done_port", 32'({done1, done0}), t.port ? 32'd2 : 32'd1);
            checkOutput("rdata",     32'(rdata),          32'(t.rdata));
            checkOutput("err",       32'(err),            32'(t.err));
          end
        end
      end
      prev_mem_req = mem_req;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors = 0; miscompares = 0; done_count = 0;
    last_rise = 0; last_interval = 0; last_done_cycle = 0;
    ram_latency = 2; ram_enable = 1'b1;
    for (int i = 0; i < 1024; i++) ram_mem[i] = '0;
    ram_mem[67]  = 20'hA1B2C;
    ram_mem[84]  = 20'h0F0F0;
    ram_mem[50]  = 20'h12345;
    ram_mem[200] = 20'h55AA5;
    rst = 1'b0;
    req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("reset_mem_req",   32'(mem_req),   32'd0);
    checkOutput("reset_mem_rw",    32'(mem_rw),    32'd0);
    checkOutput("reset_mem_addr",  32'(mem_addr),  32'd0);
    checkOutput("reset_mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("reset_done",      32'({done1, done0}), 32'd0);
    checkOutput("reset_rdata",     32'(rdata),     32'd0);
    checkOutput("reset_err",       32'(err),       32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Simultaneous requests after reset: port 0 first, then port 1
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd67, 20'h11111);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd84, 20'h22222);
    expect_txn(1'b0, 1'b0, 10'd67, 20'h11111, 20'hA1B2C, 1'b0);
    expect_txn(1'b1, 1'b0, 10'd84, 20'h22222, 20'h0F0F0, 1'b0);
    wait_done(1, 50);
    req0 = 1'b0;
    wait_done(2, 50);
    req1 = 1'b0;
    checkOutput("b2b_interval", 32'(last_interval), 32'd4);

    // Single read on port 0: mem_req one cycle after req
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd50, 20'h00000);
    expect_txn(1'b0, 1'b0, 10'd50, 20'h00000, 20'h12345, 1'b0);
    @(negedge clk);
    checkOutput("req_latency_mem_req",  32'(mem_req),  32'd1);
    checkOutput("req_latency_mem_addr", 32'(mem_addr), 32'd50);
    wait_done(3, 50);
    req0 = 1'b0;

    // Write on port 1: rdata keeps the last read line
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd148, 20'd150);
    expect_txn(1'b1, 1'b1, 10'd148, 20'd150, 20'h12345, 1'b0);
    wait_done(4, 50);
    req1 = 1'b0;
    checkOutput("ram_write_148", 32'(ram_mem[148]), 32'd150);

    // Fairness: both held for six transactions -> 0,1,0,1,0,1
    ram_latency = 1;
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd200, 20'h00000);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd300, 20'h00777);
    for (int k = 0; k < 3; k++) begin
      expect_txn(1'b0, 1'b0, 10'd200, 20'h00000, 20'h55AA5, 1'b0);
      expect_txn(1'b1, 1'b1, 10'd300, 20'h00777, 20'h55AA5, 1'b0);
    end
    wait_done(10, 200);
    req0 = 1'b0;
    req1 = 1'b0;

    // Reset mid-BUSY: outputs clear asynchronously, first tie goes to port 0
    ram_latency = 6;
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd50, 20'h00000);
    expect_txn(1'b0, 1'b0, 10'd50, 20'h00000, 20'h12345, 1'b0);
    @(negedge clk);
    req0 = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("async_rst_done",    32'({done1, done0}), 32'd0);
    checkOutput("async_rst_rdata",   32'(rdata),   32'd0);
    exp_q.delete();
    repeat (8) @(negedge clk);
    rst = 1'b1;
    ram_latency = 2;
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd67, 20'h00000);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd84, 20'h00000);
    expect_txn(1'b0, 1'b0, 10'd67, 20'h00000, 20'hA1B2C, 1'b0);
    expect_txn(1'b1, 1'b0, 10'd84, 20'h00000, 20'h0F0F0, 1'b0);
    wait_done(11, 50);
    req0 = 1'b0;
    wait_done(12, 50);
    req1 = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
    // Timeout: RAM never answers, done0 lands 16 cycles after mem_req rose
    ram_enable = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd67, 20'h00000);
    expect_txn(1'b0, 1'b0, 10'd67, 20'h00000, 20'h00000, 1'b1);
    wait_done(13, 60);
    req0 = 1'b0;
    checkOutput("timeout_cycles", 32'(last_done_cycle - last_rise), 32'd16);
    repeat (4) @(negedge clk);
    checkOutput("err_sticky", 32'(err), 32'd1);
    ram_enable = 1'b1;
`endif

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
